// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package instr_fetch_pkg;

    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned WAIT_CNT_W = 4;

    // Substituted for any faulting fetch (addi x0, x0, 0).
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

    // Response payload carried on the response channel.
    typedef struct packed {
        logic               error;
        logic [INSTR_W-1:0] instr;
    } fetch_resp_t;

endpackage

// File: rtl/fetch_mem_array.sv
// DEPTH x 32 instruction storage: synchronous write, asynchronous read. Not reset.
module fetch_mem_array
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [INSTR_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [INSTR_W-1:0]       rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Program-load write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read sees pre-edge contents, so a same-edge write is not observed.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: valid/ready request in, instruction word out
// after WAIT_STATES wait cycles; faulting fetches return NOP with error set.
// Optional INSTR_FETCH_STATS_EN adds fetch_count / error_count outputs.
module instr_fetch_responder
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [INSTR_W-1:0]       resp_instr,
    output logic                     resp_error,
`ifdef INSTR_FETCH_STATS_EN
    output logic [31:0]              fetch_count,
    output logic [15:0]              error_count,
`endif
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [INSTR_W-1:0]       load_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    fetch_state_e          state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    fetch_resp_t           resp_q, resp_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;

    logic [ADDR_W-1:0]     sample_addr;
    logic [IDX_W-1:0]      rd_idx;
    logic [INSTR_W-1:0]    rd_data;
    fetch_resp_t           sample_resp;

    // With zero wait states the sample edge is the accept edge, so use the live address.
    assign sample_addr = (state_q == IDLE) ? req_addr : addr_q;
    assign rd_idx      = sample_addr[2 +: IDX_W];

    fetch_mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (load_en),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // Fault check and data select for the word about to be presented.
    always_comb begin
        sample_resp.error = 1'b0;
        sample_resp.instr = rd_data;
        if ((sample_addr[1:0] != 2'b00) || (sample_addr[ADDR_W-1:2] >= WORD_LIMIT)) begin
            sample_resp.error = 1'b1;
            sample_resp.instr = NOP_INSTR;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        resp_d     = resp_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d = req_addr;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        resp_d  = sample_resp;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = RESP;
                    resp_d  = sample_resp;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            addr_q       <= '0;
            resp_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            addr_q       <= addr_d;
            resp_q       <= resp_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_instr = resp_q.instr;
    assign resp_error = resp_q.error;

`ifdef INSTR_FETCH_STATS_EN
    // Handshake counters: total wraps, errors saturate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
            error_count <= '0;
        end else if (resp_valid_q && resp_ready) begin
            fetch_count <= fetch_count + 32'd1;
            if (resp_q.error && (error_count != 16'hFFFF)) begin
                error_count <= error_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench for instr_fetch_responder: two instances (0 and 3 wait states).
module tb_instr_fetch_responder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int          WS0   = 0;
    localparam int          WS1   = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [63:0] req_addr   [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_instr [2];
    logic        resp_error [2];
    logic        load_en;
    logic [IDX_W-1:0] load_addr;
    logic [31:0] load_data;
`ifdef INSTR_FETCH_STATS_EN
    logic [31:0] fetch_count [2];
    logic [15:0] error_count [2];
`endif

    int n_cmp;
    int n_bad;
    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;
    vec_t vecs [9];

    instr_fetch_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_instr(resp_instr[0]), .resp_error(resp_error[0]),
`ifdef INSTR_FETCH_STATS_EN
        .fetch_count(fetch_count[0]), .error_count(error_count[0]),
`endif
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    instr_fetch_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_instr(resp_instr[1]), .resp_error(resp_error[1]),
`ifdef INSTR_FETCH_STATS_EN
        .fetch_count(fetch_count[1]), .error_count(error_count[1]),
`endif
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: word = addr/4, fault on nonzero addr%4 or word beyond storage.
    function automatic logic [32:0] model_resp(input logic [63:0] addr);
        logic [63:0] w;
        w = addr / 64'd4;
        if ((addr % 64'd4) != 64'd0 || w >= 64'(DEPTH)) return {1'b1, NOP};
        return {1'b0, model_mem[int'(w)]};
    endfunction

    task automatic load_word(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = IDX_W'(a);
        load_data = d;
        tick();
        load_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic do_fetch(input int i, input logic [63:0] addr, input int hold,
                            input logic [31:0] ei, input logic ee, input string tag);
        int n;
        int exp_lat;
        exp_lat = (i == 0) ? WS0 + 1 : WS1 + 1;
        chk({tag, " req_ready_idle"}, 64'(req_ready[i]), 64'd1);
        req_valid[i] = 1'b1;
        req_addr[i]  = addr;
        tick();
        req_valid[i] = 1'b0;
        req_addr[i]  = {$urandom(), $urandom()};
        n = 1;
        while (!resp_valid[i] && n < 40) begin
            chk({tag, " req_ready_wait"}, 64'(req_ready[i]), 64'd0);
            tick();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " instr"}, 64'(resp_instr[i]), 64'(ei));
        chk({tag, " error"}, 64'(resp_error[i]), 64'(ee));
        for (int k = 0; k < hold; k++) begin
            tick();
            chk({tag, " hold_valid"}, 64'(resp_valid[i]), 64'd1);
            chk({tag, " hold_instr"}, 64'(resp_instr[i]), 64'(ei));
            chk({tag, " hold_error"}, 64'(resp_error[i]), 64'(ee));
            chk({tag, " hold_req_ready"}, 64'(req_ready[i]), 64'd0);
        end
        resp_ready[i] = 1'b1;
        tick();
        resp_ready[i] = 1'b0;
        chk({tag, " valid_after_hs"}, 64'(resp_valid[i]), 64'd0);
        chk({tag, " ready_after_hs"}, 64'(req_ready[i]), 64'd1);
    endtask

    initial begin
        logic [63:0] addr;
        logic [32:0] exp_r;
        int          inst;
        int          sel;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_addr[i]   = '0;
            resp_ready[i] = 1'b0;
        end

        // Reset values.
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst req_ready", 64'(req_ready[i]), 64'd1);
            chk("rst resp_valid", 64'(resp_valid[i]), 64'd0);
            chk("rst resp_instr", 64'(resp_instr[i]), 64'd0);
            chk("rst resp_error", 64'(resp_error[i]), 64'd0);
`ifdef INSTR_FETCH_STATS_EN
            chk("rst fetch_count", 64'(fetch_count[i]), 64'd0);
            chk("rst error_count", 64'(error_count[i]), 64'd0);
`endif
        end
        reset = 1'b1;
        tick();

        // Program image: word k = A500_00kk, word 5 = DEADBEEF.
        for (int k = 0; k < int'(DEPTH); k++) load_word(k, 32'hA500_0000 | 32'(k));
        load_word(5, 32'hDEADBEEF);

        vecs[0] = '{64'h14,                  32'hDEADBEEF, 1'b0};
        vecs[1] = '{64'h16,                  NOP,          1'b1};
        vecs[2] = '{64'h40,                  NOP,          1'b1};
        vecs[3] = '{64'h3C,                  32'hA500_000F, 1'b0};
        vecs[4] = '{64'h3D,                  NOP,          1'b1};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFC, NOP,          1'b1};
        vecs[6] = '{64'h0,                   32'hA500_0000, 1'b0};
        vecs[7] = '{64'h1C,                  32'hA500_0007, 1'b0};
        vecs[8] = '{64'h1_0000_0000,         NOP,          1'b1};

        for (int i = 0; i < 2; i++) begin
            for (int v = 0; v < 9; v++) begin
                do_fetch(i, vecs[v].addr, 0, vecs[v].instr, vecs[v].err, "table");
            end
        end

        // Response held under back-pressure for 5 cycles.
        do_fetch(1, 64'h0, 5, 32'hA500_0000, 1'b0, "hold");

        // Load to word 7 on the edge that samples it: old data returned.
        req_valid[0] = 1'b1;
        req_addr[0]  = 64'h1C;
        load_en      = 1'b1;
        load_addr    = IDX_W'(7);
        load_data    = 32'h1;
        tick();
        req_valid[0] = 1'b0;
        load_en      = 1'b0;
        model_mem[7] = 32'h1;
        chk("collide valid", 64'(resp_valid[0]), 64'd1);
        chk("collide instr_old", 64'(resp_instr[0]), 64'hA500_0007);
        chk("collide error", 64'(resp_error[0]), 64'd0);
        resp_ready[0] = 1'b1;
        tick();
        resp_ready[0] = 1'b0;
        do_fetch(0, 64'h1C, 0, 32'h1, 1'b0, "collide_next");

        // Reset while in WAIT discards the fetch.
        req_valid[1] = 1'b1;
        req_addr[1]  = 64'h8;
        tick();
        req_valid[1] = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst resp_valid", 64'(resp_valid[1]), 64'd0);
        chk("midrst req_ready", 64'(req_ready[1]), 64'd1);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("postrst resp_valid", 64'(resp_valid[1]), 64'd0);
            chk("postrst req_ready", 64'(req_ready[1]), 64'd1);
        end
        do_fetch(1, 64'h8, 1, 32'hA500_0002, 1'b0, "postrst");

`ifdef INSTR_FETCH_STATS_EN
        // Counters on dut0 were cleared by the reset above.
        do_fetch(0, 64'h0, 0, 32'hA500_0000, 1'b0, "stats");
        do_fetch(0, 64'h4, 1, 32'hA500_0001, 1'b0, "stats");
        do_fetch(0, 64'h2, 0, NOP, 1'b1, "stats");
        do_fetch(0, 64'h8, 2, 32'hA500_0002, 1'b0, "stats");
        do_fetch(0, 64'h40, 0, NOP, 1'b1, "stats");
        chk("stats fetch_count", 64'(fetch_count[0]), 64'd5);
        chk("stats error_count", 64'(error_count[0]), 64'd2);
`endif

        // Randomised fetches against the reference model.
        for (int t = 0; t < 40; t++) begin
            inst = int'($urandom_range(0, 1));
            sel  = int'($urandom_range(0, 3));
            case (sel)
                0: addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd4;
                1: addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd4 + 64'($urandom_range(1, 3));
                2: addr = 64'(DEPTH * 4) + 64'($urandom_range(0, 255));
                default: addr = {$urandom(), $urandom()};
            endcase
            if ($urandom_range(0, 2) == 0) begin
                load_word(int'($urandom_range(0, DEPTH - 1)), $urandom());
            end
            exp_r = model_resp(addr);
            do_fetch(inst, addr, int'($urandom_range(0, 3)), exp_r[31:0], exp_r[32], "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
